// File: rtl/pwm_bram_pkg.sv
// Shared constants and level-slicing helpers for the BRAM-fed PWM DAC.
package pwm_bram_pkg;

  localparam int LEVEL_WIDTH = 16;

  // Top pwm_width bits of the level: the per-period duty count.
  function automatic logic [LEVEL_WIDTH-1:0] duty(input logic [LEVEL_WIDTH-1:0] level,
                                                   input int pwm_width);
    return level >> (LEVEL_WIDTH - pwm_width);
  endfunction

  // Remaining low bits: the sub-LSB part fed to the sigma-delta accumulator.
  function automatic logic [LEVEL_WIDTH-1:0] frac(input logic [LEVEL_WIDTH-1:0] level,
                                                   input int pwm_width);
    return level & ((LEVEL_WIDTH'(1) << (LEVEL_WIDTH - pwm_width)) - LEVEL_WIDTH'(1));
  endfunction

endpackage

// File: rtl/pwm_bram_channel.sv
// One PWM output: first-order sigma-delta on the fractional bits, reloaded once per period.
module pwm_bram_channel
  import pwm_bram_pkg::*;
#(
  parameter int PWM_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [PWM_WIDTH-1:0]   cnt_next,
  input  logic [LEVEL_WIDTH-1:0] level,
  output logic                   pwm
);

  localparam int FRAC_WIDTH = LEVEL_WIDTH - PWM_WIDTH;

  logic [PWM_WIDTH-1:0]  duty_v;
  logic [FRAC_WIDTH-1:0] frac_v;
  logic [FRAC_WIDTH-1:0] acc;
  logic [FRAC_WIDTH:0]   acc_sum;
  logic [PWM_WIDTH:0]    high;
  logic [PWM_WIDTH:0]    high_next;

  always_comb begin
    duty_v    = PWM_WIDTH'(duty(level, PWM_WIDTH));
    frac_v    = FRAC_WIDTH'(frac(level, PWM_WIDTH));
    acc_sum   = {1'b0, acc} + {1'b0, frac_v};
    high_next = high;
    if (load) begin
      high_next = {1'b0, duty_v} + {{PWM_WIDTH{1'b0}}, acc_sum[FRAC_WIDTH]};
    end
  end

  // high_next feeds the compare so the first clock of a new period already uses the new level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      high <= '0;
      pwm  <= 1'b0;
    end else begin
      if (load) begin
        acc <= acc_sum[FRAC_WIDTH-1:0];
      end
      high <= high_next;
      pwm  <= ({1'b0, cnt_next} < high_next);
    end
  end

endmodule

// File: rtl/pwm_bram.sv
// Host-writable slow DAC: BRAM-port shadow levels drive one dithered PWM pin per channel.
module pwm_bram
  import pwm_bram_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int PWM_WIDTH  = 8
) (
  input  logic                   a_bram_clk,
  input  logic                   a_bram_rst,
  input  logic                   a_bram_en,
  input  logic [1:0]             a_bram_we,
  input  logic [ADDR_WIDTH-1:0]  a_bram_addr,
  input  logic [LEVEL_WIDTH-1:0] a_bram_wdata,
  output logic [LEVEL_WIDTH-1:0] a_bram_rdata,
  output logic [CHANNELS-1:0]    pwm_out,
  output logic                   period_sync
);

  localparam logic [PWM_WIDTH-1:0] CNT_MAX = '1;

  logic [LEVEL_WIDTH-1:0] shadow [CHANNELS];
  logic [PWM_WIDTH-1:0]   cnt;
  logic [PWM_WIDTH-1:0]   cnt_next;
  logic                   load;
  logic                   addr_hit;
  logic [LEVEL_WIDTH-1:0] rd_mux;

  assign cnt_next = cnt + 1'b1;
  assign load     = (cnt == CNT_MAX);

  always_comb begin
    addr_hit = 1'b0;
    rd_mux   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (a_bram_addr == ADDR_WIDTH'(i)) begin
        addr_hit = 1'b1;
        rd_mux   = shadow[i];
      end
    end
  end

  // Port protocol: every clock with en high is one access; en reads (1-cycle latency,
  // old data on same-address write), en with we!=0 additionally writes the selected byte lanes.
  always_ff @(posedge a_bram_clk or posedge a_bram_rst) begin
    if (a_bram_rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
      end
    end else if (a_bram_en && addr_hit) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (a_bram_addr == ADDR_WIDTH'(i)) begin
          if (a_bram_we[1]) shadow[i][15:8] <= a_bram_wdata[15:8];
          if (a_bram_we[0]) shadow[i][7:0]  <= a_bram_wdata[7:0];
        end
      end
    end
  end

  always_ff @(posedge a_bram_clk or posedge a_bram_rst) begin
    if (a_bram_rst) begin
      a_bram_rdata <= '0;
    end else if (a_bram_en) begin
      a_bram_rdata <= rd_mux;
    end
  end

  always_ff @(posedge a_bram_clk or posedge a_bram_rst) begin
    if (a_bram_rst) begin
      cnt         <= '0;
      period_sync <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      period_sync <= load;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pwm_bram_channel #(
      .PWM_WIDTH(PWM_WIDTH)
    ) u_ch (
      .clk      (a_bram_clk),
      .rst      (a_bram_rst),
      .load     (load),
      .cnt_next (cnt_next),
      .level    (shadow[g]),
      .pwm      (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_pwm_bram.sv
// Directed bench for pwm_bram: readback and per-period high-count scoreboards.
module tb_pwm_bram;

  localparam int CHANNELS   = 4;
  localparam int ADDR_WIDTH = 5;
  localparam int PWM_WIDTH  = 8;
  localparam int PERIOD     = 256;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  en;
  logic [1:0]            we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]           wdata;
  logic [15:0]           rdata;
  logic [CHANNELS-1:0]   pwm_out;
  logic                  period_sync;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pwm_bram #(
    .CHANNELS   (CHANNELS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .PWM_WIDTH  (PWM_WIDTH)
  ) dut (
    .a_bram_clk   (clk),
    .a_bram_rst   (rst),
    .a_bram_en    (en),
    .a_bram_we    (we),
    .a_bram_addr  (addr),
    .a_bram_wdata (wdata),
    .a_bram_rdata (rdata),
    .pwm_out      (pwm_out),
    .period_sync  (period_sync)
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] rd_q[$];
  logic [47:0] per_q[$];   // {period index[11:0], cnt ch3, ch2, ch1, ch0 (9 bits each)}
  logic        rd_req  = 1'b0;
  logic        rd_fire = 1'b0;
  int          drv_p   = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] rec(input int idx, input int c0, input int c1,
                                      input int c2, input int c3);
    return {12'(idx), 9'(c3), 9'(c2), 9'(c1), 9'(c0)};
  endfunction

  // ---------------- readback monitor ----------------
  always @(posedge clk) rd_fire = en && rd_req && !rst;

  always @(negedge clk) begin
    if (rd_fire) begin
      if (rd_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rdata_unexpected: got %0h, expected no read", rdata);
      end else begin
        check("rdata", {32'h0, rdata}, {32'h0, rd_q.pop_front()});
      end
    end
  end

  // ---------------- period monitor ----------------
  int         hi_cnt [CHANNELS];
  int         clk_in_period = 0;
  int         mon_idx = 0;
  bit         in_period = 1'b0;
  logic [3:0] prev_pwm = '0;

  task automatic finalize_period(input int k);
    logic [47:0] e;
    logic [35:0] act;
    act = {9'(hi_cnt[3]), 9'(hi_cnt[2]), 9'(hi_cnt[1]), 9'(hi_cnt[0])};
    check($sformatf("period_len p%0d", k), 48'(clk_in_period), 48'(PERIOD));
    while (per_q.size() > 0) begin
      e = per_q[0];
      if (e[47:36] < 12'(k)) begin
        void'(per_q.pop_front());
        n_cmp++;
        n_fail++;
        $display("FAIL period_missed: got no period %0d observed, expected counts %0h", e[47:36], e[35:0]);
      end else begin
        break;
      end
    end
    if (per_q.size() > 0) begin
      e = per_q[0];
      if (e[47:36] == 12'(k)) begin
        void'(per_q.pop_front());
        check($sformatf("high_counts p%0d", k), {12'h0, act}, {12'h0, e[35:0]});
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      in_period     = 1'b0;
      mon_idx       = 0;
      clk_in_period = 0;
      prev_pwm      = '0;
    end else begin
      if (period_sync) begin
        if (in_period) finalize_period(mon_idx);
        mon_idx++;
        in_period     = 1'b1;
        clk_in_period = 0;
        for (int c = 0; c < CHANNELS; c++) hi_cnt[c] = 0;
      end
      if (in_period) begin
        clk_in_period++;
        for (int c = 0; c < CHANNELS; c++) begin
          if (pwm_out[c]) hi_cnt[c]++;
          if (pwm_out[c] && !prev_pwm[c]) check($sformatf("rise_at_sync ch%0d", c),
                                                48'(period_sync), 48'(1));
        end
      end
      prev_pwm = pwm_out;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bram_op(input logic [ADDR_WIDTH-1:0] a, input logic [1:0] w,
                         input logic [15:0] d, input bit rd, input logic [15:0] exp);
    @(posedge clk); #1;
    en = 1'b1; we = w; addr = a; wdata = d; rd_req = rd;
    if (rd) rd_q.push_back(exp);
    @(posedge clk); #1;
    en = 1'b0; we = 2'b00; rd_req = 1'b0;
  endtask

  task automatic wait_sync(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_sync && n < 300);
    if (!period_sync) begin
      n_cmp++;
      n_fail++;
      $display("FAIL sync_timeout: got no period_sync in %0d clocks, expected one", n);
    end
    drv_p++;
  endtask

  task automatic next_period(input int c0, input int c1, input int c2, input int c3);
    int n;
    wait_sync(n);
    per_q.push_back(rec(drv_p, c0, c1, c2, c3));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst = 1'b1; en = 1'b0; we = 2'b00; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset pwm_out", 48'(pwm_out), 48'(0));
    check("reset period_sync", 48'(period_sync), 48'(0));
    check("reset rdata", 48'(rdata), 48'(0));
    @(negedge clk) rst = 1'b0;
    drv_p = 0;

    wait_sync(n);
    check("first sync after release", 48'(n), 48'(PERIOD));
    per_q.push_back(rec(drv_p, 0, 0, 0, 0));
    bram_op(5'd0, 2'b11, 16'h8000, 1'b0, 16'h0);
    bram_op(5'd1, 2'b11, 16'h0080, 1'b0, 16'h0);
    bram_op(5'd2, 2'b11, 16'hFFFF, 1'b0, 16'h0);
    bram_op(5'd0, 2'b00, 16'h0, 1'b1, 16'h8000);
    bram_op(5'd1, 2'b00, 16'h0, 1'b1, 16'h0080);

    next_period(128, 0, 255, 0);   // p2
    next_period(128, 1, 256, 0);   // p3
    next_period(128, 0, 256, 0);   // p4
    bram_op(5'd2, 2'b11, 16'h0000, 1'b0, 16'h0);
    bram_op(5'd0, 2'b01, 16'h12AB, 1'b0, 16'h0);
    bram_op(5'd7, 2'b11, 16'hBEEF, 1'b0, 16'h0);
    bram_op(5'd7, 2'b00, 16'h0, 1'b1, 16'h0000);
    bram_op(5'd0, 2'b00, 16'h0, 1'b1, 16'h80AB);
    bram_op(5'd2, 2'b00, 16'h0, 1'b1, 16'h0000);

    next_period(128, 1, 0, 0);     // p5
    bram_op(5'd3, 2'b11, 16'h2000, 1'b0, 16'h0);
    next_period(129, 0, 0, 32);    // p6
    next_period(129, 1, 0, 32);    // p7
    next_period(128, 0, 0, 32);    // p8

    // write + read ch3 on the last clock of p8
    repeat (PERIOD - 1) @(posedge clk);
    #1;
    en = 1'b1; we = 2'b11; addr = 5'd3; wdata = 16'h4000; rd_req = 1'b1;
    rd_q.push_back(16'h2000);
    @(posedge clk); #1;
    en = 1'b0; we = 2'b00; rd_req = 1'b0;

    next_period(129, 1, 0, 32);    // p9: boundary write not yet active
    next_period(129, 0, 0, 64);    // p10
    wait_sync(n);                  // p11 start closes p10
    repeat (5) @(negedge clk);
    check("per_q drained", 48'(per_q.size()), 48'(0));
    check("rd_q drained", 48'(rd_q.size()), 48'(0));

    // reset in the middle of p11 (cnt = 105): ch0 high 128, others low
    repeat (100) @(posedge clk);
    #2;
    check("pwm before mid reset", 48'(pwm_out), 48'(4'b0001));
    rst = 1'b1;
    #1;
    check("mid reset pwm_out", 48'(pwm_out), 48'(0));
    check("mid reset period_sync", 48'(period_sync), 48'(0));
    check("mid reset rdata", 48'(rdata), 48'(0));
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    drv_p = 0;

    wait_sync(n);
    check("sync after mid reset", 48'(n), 48'(PERIOD));
    per_q.push_back(rec(drv_p, 0, 0, 0, 0));
    bram_op(5'd0, 2'b00, 16'h0, 1'b1, 16'h0000);
    bram_op(5'd3, 2'b00, 16'h0, 1'b1, 16'h0000);
    wait_sync(n);
    repeat (3) @(negedge clk);
    check("per_q drained end", 48'(per_q.size()), 48'(0));
    check("rd_q drained end", 48'(rd_q.size()), 48'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: got no end of stimulus by %0t, expected completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
